piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter. It drives the single-bit stream into the
//  registered serial shift chains used across the design (b -> a -> c style).
//  It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
//  one bit per clk, with a valid strobe and an end-of-frame strobe.
//  It sustains back-to-back words with no idle gap.
// PARAMETERS
//  WIDTH      8   data bits per word; legal range >= 2
//  MSB_FIRST  1   1: din[WIDTH-1] is sent first; 0: din[0] is sent first
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst         in   1      asynchronous, active-high reset
//  din         in   WIDTH  parallel word; sampled only on the acceptance edge
//  din_valid   in   1      producer has a word; hold high until accepted
//  din_ready   out  1      transmitter can accept a word this cycle
//  sout        out  1      serial data bit, registered
//  sout_valid  out  1      sout carries a frame bit this cycle, registered
//  sout_last   out  1      final bit of the current frame, registered
//  busy        out  1      frame in progress (state == SHIFT)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, shift reg=0, cnt=0, sout=0,
//    sout_valid=0, sout_last=0, busy=0. din_ready is gated to 0 while rst=1.
//  - FSM IDLE: din_ready=1. Acceptance (din_valid & din_ready at posedge) loads
//    din into the shift register, sets cnt=0 and moves to SHIFT.
//  - FSM SHIFT: each cycle presents one bit, cnt increments, busy=1.
//    * din_ready=1 only in the last-bit cycle (cnt==FRAME-1).
//    * Acceptance in the last-bit cycle reloads the register and stays in SHIFT.
//      This gives zero-gap back-to-back frames.
//    * If there is no acceptance in the last-bit cycle, go to IDLE.
//  - FRAME = WIDTH, or WIDTH+1 with parity enabled.
//  - Latency: a word accepted at edge t drives its first bit during cycle t+1.
//    Its last bit is on cycle t+FRAME. Throughput is 1 word per FRAME cycles.
//  - sout_last=1 together with the final bit only.
//  - When sout_valid=0, sout=0, so the idle line is low.
//  - din_valid while din_ready=0: ignored, with no side effect; din is don't-care.
//  - Reset mid-frame: the frame is aborted and outputs clear asynchronously.
//    No partial bits resume; the next accepted word starts at its first bit.
//  - cnt width is $clog2(WIDTH+1). cnt saturates, so the counter never wraps.
// CONFIGURATION
//  PISO_PARITY_EN defined:
//    * After the data bits, send one even-parity bit (^ of the accepted word).
//      FRAME = WIDTH+1.
//    * sout_last and din_ready move to the parity cycle.
//  PISO_PARITY_EN undefined:
//    * FRAME = WIDTH and no parity logic is built.
// TESTING
//  1 Reset: rst=1 for 20ns, clk running -> sout=0, sout_valid=0, busy=0,
//    din_ready=0. After release -> din_ready=1 on the next cycle.
//  2 WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at edge t -> sout=1,0,1,0,0,1,0,1
//    on cycles t+1..t+8. sout_valid high for exactly 8 cycles, sout_last at t+8.
//  3 Back-to-back: 8'hF0 then 8'h0F with din_valid held -> 16 contiguous valid
//    bits 1111000000001111, no gap. din_ready high only at t and t+8.
//  4 MSB_FIRST=0, din=8'h01 -> sout=1 then seven 0s; sout_last on the 8th bit.
//  5 Send 8'hFF and assert rst after 3 bits -> sout_valid=0 and sout=0 at once.
//    After release, accept 8'h80 -> sout=1,0,0,0,0,0,0,0 from its first bit.
//  6 PISO_PARITY_EN, din=8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1, sout_last on the 9th.
//    With din=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready input and zero-gap back-to-back frames.
// Optional even-parity bit after the data bits when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q, shift_d, load_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_valid_q, sout_last_q;
    logic             load_bit, next_bit, next_out;
    logic             at_last, accept;

    // The first bit goes straight to sout on load; the register keeps only the remainder.
    always_comb begin
        load_bit = 1'b0;
        load_d   = '0;
        next_bit = 1'b0;
        shift_d  = '0;
        if (MSB_FIRST) begin
            load_bit = din[WIDTH-1];
            load_d   = {din[WIDTH-2:0], 1'b0};
            next_bit = shift_q[WIDTH-1];
            shift_d  = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            load_bit = din[0];
            load_d   = {1'b0, din[WIDTH-1:1]};
            next_bit = shift_q[0];
            shift_d  = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         parity_q <= 1'b0;
        else if (accept) parity_q <= ^din;
    end

    assign next_out = (cnt_q == DATA_LAST) ? parity_q : next_bit;
`else
    assign next_out = next_bit;
`endif

    assign at_last   = (cnt_q == LAST_CNT);
    assign cnt_d     = at_last ? cnt_q : cnt_q + CW'(1);
    assign din_ready = !rst && ((state_q == IDLE) || at_last);
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else if (accept) begin
            state_q      <= SHIFT;
            shift_q      <= load_d;
            cnt_q        <= '0;
            sout_q       <= load_bit;
            sout_valid_q <= 1'b1;
            sout_last_q  <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (at_last) begin
                state_q      <= IDLE;
                sout_q       <= 1'b0;
                sout_valid_q <= 1'b0;
                sout_last_q  <= 1'b0;
            end else begin
                shift_q      <= shift_d;
                cnt_q        <= cnt_d;
                sout_q       <= next_out;
                sout_last_q  <= (cnt_d == LAST_CNT);
            end
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: an MSB-first and an LSB-first instance share the input side.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk, rst, din_valid;
    logic [W-1:0] din;
    logic         rdy_m, so_m, sv_m, sl_m, bs_m;
    logic         rdy_l, so_l, sv_l, sl_l, bs_l;

    exp_t qm[$];
    exp_t ql[$];
    int   total = 0;
    int   bad   = 0;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .sout(so_m), .sout_valid(sv_m), .sout_last(sl_m), .busy(bs_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .sout(so_l), .sout_valid(sv_l), .sout_last(sl_l), .busy(bs_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is the word's bits in send order, then optional parity; last marks bit FRAME-1.
    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.last = (i == FRAME - 1);
            e.b = w[W-1-i];
            qm.push_back(e);
            e.b = w[i];
            ql.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.last = 1'b1;
        e.b = ^w;
        qm.push_back(e);
        ql.push_back(e);
`endif
    endtask

    task automatic mon_one(input string tag, input bit lsb,
                           input logic so, input logic sv, input logic sl,
                           input logic rd, input logic bs);
        exp_t e;
        logic has;
        has = lsb ? (ql.size() != 0) : (qm.size() != 0);
        e = '0;
        if (has) e = lsb ? ql[0] : qm[0];
        chk({tag, "_valid"}, sv, has);
        chk({tag, "_sout"},  so, has ? e.b : 1'b0);
        chk({tag, "_last"},  sl, has ? e.last : 1'b0);
        chk({tag, "_ready"}, rd, !has || e.last);
        chk({tag, "_busy"},  bs, has);
        if (has) begin
            if (lsb) void'(ql.pop_front());
            else     void'(qm.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk("rst_sout",  so_m | so_l, 1'b0);
                chk("rst_valid", sv_m | sv_l, 1'b0);
                chk("rst_last",  sl_m | sl_l, 1'b0);
                chk("rst_busy",  bs_m | bs_l, 1'b0);
                chk("rst_ready", rdy_m | rdy_l, 1'b0);
            end else begin
                mon_one("msb", 1'b0, so_m, sv_m, sl_m, rdy_m, bs_m);
                mon_one("lsb", 1'b1, so_l, sv_l, sl_l, rdy_l, bs_l);
            end
        end
    end

    // Inputs change at the falling edge; acceptance is decided just before the rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
        @(negedge clk);
        rst = r;
        if (r) begin
            qm.delete();
            ql.delete();
        end
        din_valid = v;
        din = d;
        #3;
        acc = v && rdy_m && !r;
        if (acc) push_word(d);
    endtask

    task automatic send(input logic [W-1:0] w);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            step(1'b1, w, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: word %h not accepted, required within 64 cycles", w);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((qm.size() != 0 || ql.size() != 0) && n < 64) begin
            step(1'b0, W'($urandom), 1'b0, acc);
            n++;
        end
        step(1'b0, '0, 1'b0, acc);
        if (qm.size() != 0 || ql.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d bits left, required 0", qm.size() + ql.size());
        end
    endtask

    initial begin
        logic         acc, v, r;
        logic [W-1:0] d;
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        acc = 1'b0;
        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        step(1'b1, 8'h3C, 1'b1, acc);
        step(1'b0, '0, 1'b0, acc);

        send(8'hA5);
        drain();
        send(8'hF0);
        send(8'h0F);
        drain();
        send(8'h01);
        drain();
        send(8'h07);
        drain();
        send(8'h03);
        drain();

        send(8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, acc);
        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        send(8'h80);
        drain();

        v = 1'b0;
        d = '0;
        acc = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 149) == 0);
            if (!(v && !acc)) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
            end else if (!rdy_m) begin
                d = d;
            end
            step(v, d, r, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
